// File: rtl/liteeth_sram_pkg.sv
// Shared types and helpers for the liteeth 1rwNr behavioural SRAM.
//  - collision_mode_e : what a read port returns when rw0 writes the same word on the same edge
//  - merge_lanes      : replace the lanes of a word selected by a lane mask
//  - params_legal     : parameter sanity check used at elaboration by the top
package liteeth_sram_pkg;

  typedef enum logic {
    COLL_OLD_DATA      = 1'b0,
    COLL_WRITE_THROUGH = 1'b1
  } collision_mode_e;

  // Helpers operate on a fixed maximum width; callers zero-extend and truncate.
  localparam int unsigned MaxBits  = 1024;
  localparam int unsigned MaxLanes = 128;

  // Bit b belongs to lane b/lane_bits; lanes with mask=1 take new_w, others keep old_w.
  function automatic logic [MaxBits-1:0] merge_lanes(input logic [MaxBits-1:0]  old_w,
                                                     input logic [MaxBits-1:0]  new_w,
                                                     input logic [MaxLanes-1:0] mask,
                                                     input int unsigned         lane_bits);
    logic [MaxBits-1:0] res;
    res = old_w;
    if (lane_bits != 0) begin
      for (int unsigned b = 0; b < MaxBits; b++) begin
        if ((b / lane_bits) < MaxLanes) begin
          if (mask[b / lane_bits]) res[b] = new_w[b];
        end
      end
    end
    return res;
  endfunction

  function automatic bit params_legal(input int unsigned bits,
                                      input int unsigned word_depth,
                                      input int unsigned addr_width,
                                      input int unsigned num_r,
                                      input int unsigned wmask_width,
                                      input int unsigned read_latency,
                                      input int unsigned rw_collision);
    bit ok;
    ok = 1'b1;
    if (bits == 0 || bits > MaxBits) ok = 1'b0;
    if (wmask_width == 0 || wmask_width > MaxLanes) ok = 1'b0;
    else if ((bits % wmask_width) != 0) ok = 1'b0;
    if (word_depth == 0) ok = 1'b0;
    if (addr_width == 0 || addr_width > 31) ok = 1'b0;
    else if ((32'd1 << addr_width) < word_depth) ok = 1'b0;
    if (num_r < 1 || num_r > 4) ok = 1'b0;
    if (read_latency < 1 || read_latency > 2) ok = 1'b0;
    if (rw_collision > 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/liteeth_sram_rd_pipe.sv
// Read-return pipeline for one SRAM port.
//  clk, rst_n    : clock, asynchronous active-low reset
//  vld_in        : a read is issued at this edge
//  oor_in        : the issued address is out of range; returned data is forced to 0
//  word_in       : raw word for the issued address (already collision-resolved)
//  rd_out        : read data, holds its value until the next completed read
//  rd_valid_out  : one-cycle pulse per completed read
// READ_LATENCY=1 returns data after the issuing edge; 2 adds one register stage.
module liteeth_sram_rd_pipe
  import liteeth_sram_pkg::*;
#(
  parameter int unsigned BITS         = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vld_in,
  input  logic            oor_in,
  input  logic [BITS-1:0] word_in,
  output logic [BITS-1:0] rd_out,
  output logic            rd_valid_out
);

  logic [BITS-1:0] s1_data_q;
  logic            s1_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      s1_vld_q <= vld_in;
      if (vld_in) s1_data_q <= oor_in ? '0 : word_in;
    end
  end

  if (READ_LATENCY >= 2) begin : g_lat2
    logic [BITS-1:0] s2_data_q;
    logic            s2_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data_q <= '0;
        s2_vld_q  <= 1'b0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) s2_data_q <= s1_data_q;
      end
    end

    assign rd_out       = s2_data_q;
    assign rd_valid_out = s2_vld_q;
  end else begin : g_lat1
    assign rd_out       = s1_data_q;
    assign rd_valid_out = s1_vld_q;
  end

endmodule

// File: rtl/liteeth_1rwnr_sram.sv
// Behavioural SRAM with one read/write port (rw0) and NUM_R read-only ports on one clock.
//  rw0_ce_in/we_in/wmask_in/addr_in/wd_in : rw0 access, byte(lane)-masked write or read
//  rw0_rd_out, rw0_rd_valid_out           : rw0 read data and its valid pulse
//  r_ce_in, r_addr_in                     : per read port enable and packed addresses
//  r_rd_out, r_rd_valid_out               : per read port packed data and valid pulses
//  oor_err_out                            : sticky flag, any enabled access with addr >= WORD_DEPTH
// The array is not reset; only the read pipelines and the error flag are.
module liteeth_1rwnr_sram
  import liteeth_sram_pkg::*;
#(
  parameter int unsigned BITS               = 32,
  parameter int unsigned WORD_DEPTH         = 384,
  parameter int unsigned ADDR_WIDTH         = 9,
  parameter int unsigned NUM_R              = 1,
  parameter int unsigned WMASK_WIDTH        = 4,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned RW_COLLISION       = 0,
  parameter bit          corrupt_mem_on_X_p = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rw0_ce_in,
  input  logic                        rw0_we_in,
  input  logic [WMASK_WIDTH-1:0]      rw0_wmask_in,
  input  logic [ADDR_WIDTH-1:0]       rw0_addr_in,
  input  logic [BITS-1:0]             rw0_wd_in,
  output logic [BITS-1:0]             rw0_rd_out,
  output logic                        rw0_rd_valid_out,
  input  logic [NUM_R-1:0]            r_ce_in,
  input  logic [NUM_R*ADDR_WIDTH-1:0] r_addr_in,
  output logic [NUM_R*BITS-1:0]       r_rd_out,
  output logic [NUM_R-1:0]            r_rd_valid_out,
  output logic                        oor_err_out
);

  localparam int unsigned       LaneBits = BITS / WMASK_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam collision_mode_e   CollMode = collision_mode_e'(RW_COLLISION[0]);

  if (!params_legal(BITS, WORD_DEPTH, ADDR_WIDTH, NUM_R, WMASK_WIDTH, READ_LATENCY,
                    RW_COLLISION)) begin : g_param_check
    $error("liteeth_1rwnr_sram: illegal parameter combination");
  end

  logic [BITS-1:0] mem [0:WORD_DEPTH-1];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DepthLim;
  endfunction

  // rw0 decode and lane merge
  logic            rw0_ok;
  logic            rw0_wr_en;
  logic            rw0_rd_en;
  logic            rw0_oor_hit;
  logic [BITS-1:0] rw0_old;
  logic [BITS-1:0] rw0_merged;

  always_comb begin
    rw0_ok      = in_range(rw0_addr_in);
    rw0_old     = rw0_ok ? mem[rw0_addr_in] : '0;
    rw0_merged  = BITS'(merge_lanes(MaxBits'(rw0_old), MaxBits'(rw0_wd_in),
                                    MaxLanes'(rw0_wmask_in), LaneBits));
    // All-zero mask still makes this a write cycle; merged == old so nothing changes.
    rw0_wr_en   = rw0_ce_in & rw0_we_in & rw0_ok;
    rw0_rd_en   = rw0_ce_in & ~rw0_we_in;
    rw0_oor_hit = rw0_ce_in & ~rw0_ok;
  end

  // Array write. The X branches only ever fire in a 4-state simulator.
  always_ff @(posedge clk) begin
    if (corrupt_mem_on_X_p && rw0_ce_in && $isunknown(rw0_addr_in)) begin
      for (int i = 0; i < int'(WORD_DEPTH); i++) mem[i] <= 'x;
    end else if (corrupt_mem_on_X_p && rw0_ce_in && $isunknown(rw0_we_in) && rw0_ok) begin
      mem[rw0_addr_in] <= 'x;
    end else if (rw0_wr_en) begin
      mem[rw0_addr_in] <= rw0_merged;
    end
  end

  liteeth_sram_rd_pipe #(
    .BITS         (BITS),
    .READ_LATENCY (READ_LATENCY)
  ) u_rw0_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld_in       (rw0_rd_en),
    .oor_in       (~rw0_ok),
    .word_in      (rw0_old),
    .rd_out       (rw0_rd_out),
    .rd_valid_out (rw0_rd_valid_out)
  );

  logic [NUM_R-1:0] r_oor_hit;

  for (genvar i = 0; i < int'(NUM_R); i++) begin : g_rport
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ok;
    logic                  hit;
    logic [BITS-1:0]       old_word;
    logic [BITS-1:0]       word;

    assign addr = r_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      ok       = in_range(addr);
      old_word = ok ? mem[addr] : '0;
      // Same-edge write to the same word: old data, or old data with written lanes replaced.
      hit      = rw0_wr_en && (addr == rw0_addr_in);
      word     = (CollMode == COLL_WRITE_THROUGH && hit) ? rw0_merged : old_word;
    end

    assign r_oor_hit[i] = r_ce_in[i] & ~ok;

    liteeth_sram_rd_pipe #(
      .BITS         (BITS),
      .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
      .clk          (clk),
      .rst_n        (rst_n),
      .vld_in       (r_ce_in[i]),
      .oor_in       (~ok),
      .word_in      (word),
      .rd_out       (r_rd_out[i*BITS +: BITS]),
      .rd_valid_out (r_rd_valid_out[i])
    );
  end

  logic oor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q <= 1'b0;
    end else if (rw0_oor_hit || (|r_oor_hit)) begin
      oor_q <= 1'b1;
    end
  end

  assign oor_err_out = oor_q;

endmodule
